// File: rtl/int_controller_if.sv
// -----------------------------------------------------------------------------
// int_controller_if
//   CPU-side IO strobe bundle for the interrupt controller.
//   master : CPU / sequencer (drives the strobes, observes io_interrupt)
//   slave  : int_controller
//   Signals:
//     pc_in            [15:0] current program counter (return address source)
//     io_store_retaddr        capture pc_in into the return-address register
//     io_push_retaddr         drive the saved return address on d_bus
//     io_push_int_addr        drive the vector address on d_bus and claim
//     io_push_ints            drive {mask, pending} on d_bus
//     io_write                IO write strobe
//     io_addr          [3:0]  IO register address
//     io_interrupt            an unmasked interrupt is pending
//   The shared d_bus stays a plain inout port on the controller.
// -----------------------------------------------------------------------------
interface int_controller_if;
  logic [15:0] pc_in;
  logic        io_store_retaddr;
  logic        io_push_retaddr;
  logic        io_push_int_addr;
  logic        io_push_ints;
  logic        io_write;
  logic [3:0]  io_addr;
  logic        io_interrupt;

  modport master (
    output pc_in, io_store_retaddr, io_push_retaddr, io_push_int_addr,
    output io_push_ints, io_write, io_addr,
    input  io_interrupt
  );

  modport slave (
    input  pc_in, io_store_retaddr, io_push_retaddr, io_push_int_addr,
    input  io_push_ints, io_write, io_addr,
    output io_interrupt
  );
endinterface

// File: rtl/int_controller.sv
// -----------------------------------------------------------------------------
// int_controller
//   Eight-line prioritised interrupt controller (line 0 highest priority).
//   Ports:
//     clk     system clock, rising edge
//     rst_n   asynchronous active-low reset
//     irq_in  [7:0] asynchronous interrupt request lines
//     cpu     int_controller_if.slave : IO strobes, pc_in, io_interrupt
//     d_bus   [15:0] shared data bus, high-Z unless a push strobe is high
//   Parameters:
//     VECTOR_BASE  data address of vector slot 0 (slot 8 = spurious)
//     MASK_IO_ADDR IO address of the mask / write-1-to-clear register
//   Build option:
//     INT_EDGE_EN  defined   -> pending latches synchronised rising edges
//                  undefined -> pending mirrors the synchronised line level
// -----------------------------------------------------------------------------
module int_controller #(
  parameter logic [15:0] VECTOR_BASE  = 16'hFFF0,
  parameter logic [3:0]  MASK_IO_ADDR = 4'hE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        irq_in,
  int_controller_if.slave   cpu,
  inout  wire  [15:0]       d_bus
);

  logic [7:0]  sync1_r;
  logic [7:0]  sync2_r;
  logic [7:0]  mask_r;
  logic [15:0] retaddr_r;
  logic [2:0]  in_service_r;
  logic [7:0]  pending_s;
  logic [7:0]  active_s;
  logic [3:0]  claim_idx_s;
  logic        claim_hit_s;
  logic        mask_wr_s;
  logic        drive_en_s;
  logic [15:0] drive_val_s;
  logic        unused_s;

  // Index of the lowest set bit; 8 when no bit is set (spurious slot).
  function automatic logic [3:0] lowest_set(input logic [7:0] v);
    logic [3:0] idx;
    idx = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  assign active_s    = pending_s & mask_r;
  assign claim_idx_s = lowest_set(active_s);
  assign claim_hit_s = cpu.io_push_int_addr && !claim_idx_s[3];
  assign mask_wr_s   = cpu.io_write && (cpu.io_addr == MASK_IO_ADDR);

  assign cpu.io_interrupt = |active_s;

  // Two-flop synchroniser for the asynchronous request lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 8'h00;
      sync2_r <= 8'h00;
    end else begin
      sync1_r <= irq_in;
      sync2_r <= sync1_r;
    end
  end

`ifdef INT_EDGE_EN
  logic [7:0] hist_r;
  logic [7:0] pend_r;
  logic [1:0] arm_cnt_r;
  logic [7:0] rise_s;
  logic [7:0] clr_s;

  // History flop plus arming counter: detection stays off until the history
  // has followed the synchronised line for three clocks after reset, so a
  // line held high through reset release never looks like a fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_r    <= 8'h00;
      arm_cnt_r <= 2'd0;
    end else begin
      hist_r <= sync2_r;
      if (arm_cnt_r != 2'd3) begin
        arm_cnt_r <= arm_cnt_r + 2'd1;
      end else begin
        arm_cnt_r <= arm_cnt_r;
      end
    end
  end

  // Rising-edge set terms and clear terms (claim plus write-1-to-clear).
  always_comb begin
    rise_s = 8'h00;
    clr_s  = 8'h00;
    if (arm_cnt_r == 2'd3) begin
      rise_s = sync2_r & ~hist_r;
    end else begin
      rise_s = 8'h00;
    end
    clr_s = (mask_wr_s ? d_bus[7:0] : 8'h00) |
            (claim_hit_s ? (8'h01 << claim_idx_s[2:0]) : 8'h00);
  end

  // Pending register: a new edge wins over any clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r <= 8'h00;
    end else begin
      pend_r <= (pend_r & ~clr_s) | rise_s;
    end
  end

  assign pending_s = pend_r;
  // in_service is kept for debug visibility only; nothing downstream reads it.
  assign unused_s  = ^in_service_r;
`else
  // Level mode: pending is the synchronised line itself, so claims and W1C
  // writes cannot leave a lasting mark on it.
  assign pending_s = sync2_r;
  assign unused_s  = ^{in_service_r, d_bus[7:0]};
`endif

  // Mask, return address and in-service index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_r       <= 8'h00;
      retaddr_r    <= 16'h0000;
      in_service_r <= 3'd0;
    end else begin
      if (mask_wr_s) begin
        mask_r <= d_bus[15:8];
      end
      if (cpu.io_store_retaddr) begin
        retaddr_r <= cpu.pc_in;
      end
      if (claim_hit_s) begin
        in_service_r <= claim_idx_s[2:0];
      end
    end
  end

  // Bus source select with fixed priority int_addr > retaddr > ints.
  always_comb begin
    drive_en_s  = 1'b1;
    drive_val_s = 16'h0000;
    if (cpu.io_push_int_addr) begin
      drive_val_s = VECTOR_BASE + {12'h000, claim_idx_s};
    end else if (cpu.io_push_retaddr) begin
      drive_val_s = retaddr_r;
    end else if (cpu.io_push_ints) begin
      drive_val_s = {mask_r, pending_s};
    end else begin
      drive_en_s  = 1'b0;
      drive_val_s = 16'h0000;
    end
  end

  assign d_bus = drive_en_s ? drive_val_s : 16'hzzzz;

endmodule
